// File: rtl/ising_sweep_ctrl.sv
// Checkerboard sweep sequencer for an Ising lattice: seeds the RNG, alternates white/grey
// evaluate+commit phases, and pauses for measurement snapshots. Optional ISING_ANNEAL_EN adds o_beta_idx.
module ising_sweep_ctrl #(
   parameter int unsigned SWEEP_W = 16,
   parameter int unsigned MEAS_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [SWEEP_W-1:0] i_num_sweeps,
   input  logic [MEAS_W-1:0]  i_meas_interval,
   input  logic [7:0]         i_seed,
   input  logic               i_meas_ack,
   output logic               o_lfsr_seed_load,
   output logic [7:0]         o_lfsr_seed,
   output logic               o_enable_white,
   output logic               o_enable_grey,
   output logic               o_lattice_we,
   output logic               o_meas_req,
   output logic               o_busy,
   output logic               o_done,
`ifdef ISING_ANNEAL_EN
   output logic [3:0]         o_beta_idx,
`endif
   output logic [SWEEP_W-1:0] o_sweep_count
);

   localparam int unsigned SEED_W = 8;
   localparam int unsigned BETA_W = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_SEED, S_W_EVAL, S_W_COMMIT, S_G_EVAL, S_G_COMMIT, S_MEAS, S_FIN
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [SWEEP_W-1:0]   r_num, r_sweep_cnt;
   logic [MEAS_W-1:0]    r_meas_int, r_int_cnt;
   logic [SEED_W-1:0]    r_seed;
   logic [SWEEP_W:0]     w_cnt_inc;
   logic [MEAS_W:0]      w_int_inc;
   logic                 w_int_wrap, w_start_acc, w_gc_step, w_meas_done;
   logic                 w_load, w_en_w, w_en_g, w_we, w_mreq, w_busy, w_done;
   logic                 r_load, r_en_w, r_en_g, r_we, r_mreq, r_busy, r_done;

   // Counters are compared one bit wider so a full-scale count never aliases to zero
   assign w_cnt_inc   = {1'b0, r_sweep_cnt} + (SWEEP_W+1)'(1);
   assign w_int_inc   = {1'b0, r_int_cnt} + (MEAS_W+1)'(1);
   assign w_int_wrap  = (w_int_inc == {1'b0, r_meas_int});
   assign w_start_acc = (r_state == S_IDLE) && i_start && !i_abort;
   assign w_gc_step   = (r_state == S_G_COMMIT) && !i_abort;
   assign w_meas_done = (r_state == S_MEAS) && i_meas_ack && !i_abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort && r_state != S_IDLE) begin
         w_state_nxt = S_IDLE;
      end else begin
         unique case (r_state)
            S_IDLE:     if (w_start_acc) w_state_nxt = S_SEED;
            S_SEED:     w_state_nxt = (r_num == '0) ? S_FIN : S_W_EVAL;
            S_W_EVAL:   w_state_nxt = S_W_COMMIT;
            S_W_COMMIT: w_state_nxt = S_G_EVAL;
            S_G_EVAL:   w_state_nxt = S_G_COMMIT;
            S_G_COMMIT: begin
               if (r_meas_int != '0 && w_int_wrap)   w_state_nxt = S_MEAS;
               else if (w_cnt_inc == {1'b0, r_num}) w_state_nxt = S_FIN;
               else                                 w_state_nxt = S_W_EVAL;
            end
            S_MEAS:     if (i_meas_ack) w_state_nxt = (r_sweep_cnt == r_num) ? S_FIN : S_W_EVAL;
            S_FIN:      w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Strobes decoded from the next state and registered so they align with the state register
   always_comb begin
      w_load = 1'b0;
      w_en_w = 1'b0;
      w_en_g = 1'b0;
      w_we   = 1'b0;
      w_mreq = 1'b0;
      w_done = 1'b0;
      w_busy = (w_state_nxt != S_IDLE);
      unique case (w_state_nxt)
         S_SEED:     w_load = 1'b1;
         S_W_EVAL:   w_en_w = 1'b1;
         S_G_EVAL:   w_en_g = 1'b1;
         S_W_COMMIT: w_we   = 1'b1;
         S_G_COMMIT: w_we   = 1'b1;
         S_MEAS:     w_mreq = 1'b1;
         S_FIN:      w_done = 1'b1;
         default:    ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load <= 1'b0;
         r_en_w <= 1'b0;
         r_en_g <= 1'b0;
         r_we   <= 1'b0;
         r_mreq <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_load <= w_load;
         r_en_w <= w_en_w;
         r_en_g <= w_en_g;
         r_we   <= w_we;
         r_mreq <= w_mreq;
         r_busy <= w_busy;
         r_done <= w_done;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num       <= '0;
         r_meas_int  <= '0;
         r_seed      <= '0;
         r_sweep_cnt <= '0;
         r_int_cnt   <= '0;
      end else if (w_start_acc) begin
         r_num       <= i_num_sweeps;
         r_meas_int  <= i_meas_interval;
         r_seed      <= i_seed;
         r_sweep_cnt <= '0;
         r_int_cnt   <= '0;
      end else if (w_gc_step) begin
         r_sweep_cnt <= w_cnt_inc[SWEEP_W-1:0];
         r_int_cnt   <= w_int_wrap ? '0 : w_int_inc[MEAS_W-1:0];
      end
   end

`ifdef ISING_ANNEAL_EN
   logic [BETA_W-1:0] r_beta;

   // Temperature index advances once per completed measurement, saturating at the top entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            r_beta <= '0;
      else if (w_start_acc)                  r_beta <= '0;
      else if (w_meas_done && r_beta != '1)  r_beta <= r_beta + BETA_W'(1);
   end
   assign o_beta_idx = r_beta;
`else
   logic w_unused;
   assign w_unused = w_meas_done & (BETA_W != 0);
`endif

   assign o_lfsr_seed_load = r_load;
   assign o_lfsr_seed      = r_seed;
   assign o_enable_white   = r_en_w;
   assign o_enable_grey    = r_en_g;
   assign o_lattice_we     = r_we;
   assign o_meas_req       = r_mreq;
   assign o_busy           = r_busy;
   assign o_done           = r_done;
   assign o_sweep_count    = r_sweep_cnt;

endmodule

// File: tb/tb_ising_sweep_ctrl.sv
// Bench for ising_sweep_ctrl: builds the expected per-cycle strobe trace of each run from the
// sweep/measurement rules and compares it against the DUT every cycle.
module tb_ising_sweep_ctrl;

   localparam int unsigned SW = 5;
   localparam int unsigned MW = 8;

   localparam logic [6:0] V_IDLE = 7'b0000000;
   localparam logic [6:0] V_SEED = 7'b1000010;
   localparam logic [6:0] V_W    = 7'b0100010;
   localparam logic [6:0] V_WC   = 7'b0001010;
   localparam logic [6:0] V_G    = 7'b0010010;
   localparam logic [6:0] V_GC   = 7'b0001010;
   localparam logic [6:0] V_MEAS = 7'b0000110;
   localparam logic [6:0] V_FIN  = 7'b0000011;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start, i_abort, i_meas_ack;
   logic [SW-1:0] i_num_sweeps;
   logic [MW-1:0] i_meas_interval;
   logic [7:0]    i_seed;
   logic          o_lfsr_seed_load, o_enable_white, o_enable_grey, o_lattice_we;
   logic          o_meas_req, o_busy, o_done;
   logic [7:0]    o_lfsr_seed;
   logic [SW-1:0] o_sweep_count;
`ifdef ISING_ANNEAL_EN
   logic [3:0]    o_beta_idx;
`endif

   ising_sweep_ctrl #(.SWEEP_W(SW), .MEAS_W(MW)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
      .i_num_sweeps(i_num_sweeps), .i_meas_interval(i_meas_interval), .i_seed(i_seed),
      .i_meas_ack(i_meas_ack), .o_lfsr_seed_load(o_lfsr_seed_load), .o_lfsr_seed(o_lfsr_seed),
      .o_enable_white(o_enable_white), .o_enable_grey(o_enable_grey),
      .o_lattice_we(o_lattice_we), .o_meas_req(o_meas_req), .o_busy(o_busy), .o_done(o_done),
`ifdef ISING_ANNEAL_EN
      .o_beta_idx(o_beta_idx),
`endif
      .o_sweep_count(o_sweep_count)
   );

   always #5 clk = ~clk;

   logic [6:0] obs;
   assign obs = {o_lfsr_seed_load, o_enable_white, o_enable_grey, o_lattice_we,
                 o_meas_req, o_busy, o_done};

   int n_pass = 0;
   int n_tot  = 0;

   logic [6:0] q_v[$];
   int         q_cnt[$];
   bit         q_ack[$];
   int         q_beta[$];

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_tot++;
      assert (o === e) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
   endtask

   // Expected trace: one entry per cycle after the start edge
   function automatic void build(input int n, input int m, input int dly);
      int cnt = 0;
      int beta = 0;
      int d;
      q_v.delete(); q_cnt.delete(); q_ack.delete(); q_beta.delete();
      q_v.push_back(V_SEED); q_cnt.push_back(0); q_ack.push_back(0); q_beta.push_back(0);
      for (int s = 1; s <= n; s++) begin
         q_v.push_back(V_W);  q_cnt.push_back(cnt); q_ack.push_back(0); q_beta.push_back(beta);
         q_v.push_back(V_WC); q_cnt.push_back(cnt); q_ack.push_back(0); q_beta.push_back(beta);
         q_v.push_back(V_G);  q_cnt.push_back(cnt); q_ack.push_back(0); q_beta.push_back(beta);
         q_v.push_back(V_GC); q_cnt.push_back(cnt); q_ack.push_back(0); q_beta.push_back(beta);
         cnt = s;
         if (m != 0 && (s % m) == 0) begin
            d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            for (int j = 0; j <= d; j++) begin
               q_v.push_back(V_MEAS); q_cnt.push_back(cnt);
               q_ack.push_back(j == d); q_beta.push_back(beta);
            end
            if (beta < 15) beta++;
         end
      end
      q_v.push_back(V_FIN); q_cnt.push_back(cnt); q_ack.push_back(0); q_beta.push_back(beta);
   endfunction

   task automatic run(input int n, input int m, input int dly, input int abort_at, input int rst_at);
      logic [7:0] sd;
      int         last;
      sd = 8'($urandom);
      build(n, m, dly);
      last = q_v.size() - 1;
      @(negedge clk);
      i_start = 1'b1; i_abort = 1'b0; i_meas_ack = 1'b0;
      i_num_sweeps = SW'(n); i_meas_interval = MW'(m); i_seed = sd;
      for (int k = 0; k <= last; k++) begin
         @(negedge clk);
         chk($sformatf("strobes n=%0d m=%0d cyc=%0d", n, m, k), 32'(obs), 32'(q_v[k]));
         chk($sformatf("sweep_count n=%0d cyc=%0d", n, k), 32'(o_sweep_count), 32'(q_cnt[k]));
         if (q_v[k] == V_SEED) chk("lfsr_seed", 32'(o_lfsr_seed), 32'(sd));
`ifdef ISING_ANNEAL_EN
         chk($sformatf("beta_idx cyc=%0d", k), 32'(o_beta_idx), 32'(q_beta[k]));
`endif
         i_num_sweeps = SW'($urandom); i_meas_interval = MW'($urandom); i_seed = 8'($urandom);
         i_start = 1'($urandom);
         if (q_ack[k])            i_meas_ack = 1'b1;
         else if (q_v[k] == V_MEAS) i_meas_ack = 1'b0;
         else                     i_meas_ack = 1'($urandom);
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("reset strobes", 32'(obs), 32'(V_IDLE));
            chk("reset sweep_count", 32'(o_sweep_count), 32'd0);
            chk("reset lfsr_seed", 32'(o_lfsr_seed), 32'd0);
            i_meas_ack = 1'b1; i_start = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("post-reset ack ignored", 32'(obs), 32'(V_IDLE));
            i_meas_ack = 1'b0;
            return;
         end
         if (k == abort_at) begin
            i_abort = 1'b1;
            @(negedge clk);
            i_abort = 1'b0; i_start = 1'b0; i_meas_ack = 1'b0;
            chk("abort strobes", 32'(obs), 32'(V_IDLE));
            chk("abort sweep_count", 32'(o_sweep_count), 32'(q_cnt[k]));
            @(negedge clk);
            chk("abort no done", 32'(obs), 32'(V_IDLE));
            return;
         end
      end
      @(negedge clk);
      i_start = 1'b0; i_meas_ack = 1'b0;
      chk($sformatf("idle after n=%0d", n), 32'(obs), 32'(V_IDLE));
      chk($sformatf("final sweep_count n=%0d", n), 32'(o_sweep_count), 32'(q_cnt[last]));
   endtask

   initial begin
      rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_meas_ack = 1'b0;
      i_num_sweeps = '0; i_meas_interval = '0; i_seed = '0;
      repeat (2) @(negedge clk);
      chk("reset strobes", 32'(obs), 32'(V_IDLE));
      chk("reset sweep_count", 32'(o_sweep_count), 32'd0);
      rst_n = 1'b1;

      // start together with abort in IDLE is ignored
      @(negedge clk);
      i_start = 1'b1; i_abort = 1'b1; i_num_sweeps = SW'(2);
      @(negedge clk);
      i_start = 1'b0; i_abort = 1'b0;
      chk("start+abort ignored", 32'(obs), 32'(V_IDLE));

      run(3, 0, 0, -1, -1);
      run(4, 2, 3, -1, -1);
      run(0, 0, 0, -1, -1);
      run(3, 0, 0, 7, -1);
      run(2, 0, 0, -1, -1);
      run(31, 0, 0, -1, -1);
      run(31, 7, -1, -1, -1);
      for (int r = 0; r < 8; r++) begin
         run(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), -1, -1, -1);
      end
      run(6, 1, -1, int'($urandom_range(1, 20)), -1);
      run(2, 1, 3, -1, 6);
      run(3, 2, -1, -1, -1);
      run(20, 1, -1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
